// File: rtl/stage_two.sv
// stage_two: execute stage of the 16-bit pipeline (forwarding, ALU, iterative MUL/DIV, stage-three register).
// The iterative signed MUL/DIV unit and its FSM are compiled in only when STAGE_TWO_MULDIV_EN is defined.
module stage_two #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 halt_sys,
  input  logic [1:0]           in_memc,       // {mem2r, memwr}
  input  logic                 in_reg_wr,
  input  logic                 in_R0_en,
  input  logic [2*WIDTH-1:0]   in_alu,        // {a, b}
  input  logic [3:0]           in_alu_ctrl,
  input  logic                 in_haz1,
  input  logic                 in_haz2,
  input  logic                 in_haz8,
  input  logic [WIDTH-1:0]     in_instr,
  input  logic [WIDTH-1:0]     in_R1_data,
  input  logic [2*WIDTH-1:0]   s3_data,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   out_alu,
  output logic [1:0]           out_memc,
  output logic                 out_reg_wr,
  output logic                 out_R0_en,
  output logic [WIDTH-1:0]     out_instr,
  output logic [WIDTH-1:0]     out_R1_data,
  output logic                 overflow,
  output logic                 div0,
  output logic                 illegal
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_ROL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;

  // Forwarding from stage three is applied before anything else looks at the operands.
  logic [WIDTH-1:0] w_a, w_b, w_r1;
  assign w_a  = in_haz1 ? s3_data[WIDTH-1:0] : in_alu[2*WIDTH-1:WIDTH];
  assign w_b  = in_haz2 ? s3_data[WIDTH-1:0] : in_alu[WIDTH-1:0];
  assign w_r1 = in_haz8 ? s3_data[WIDTH-1:0] : in_R1_data;

  logic w_unused;
  assign w_unused = ^s3_data[2*WIDTH-1:WIDTH];

  logic [WIDTH-1:0]   w_sum, w_diff;
  logic [2*WIDTH-1:0] w_rol;
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;
  assign w_rol  = {w_a, w_a} << w_b[SW-1:0];

  logic [2*WIDTH-1:0] w_res;
  logic               w_ov, w_div0, w_ill, w_kill;

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_res  = '0;
    w_ov   = 1'b0;
    w_div0 = 1'b0;
    w_ill  = 1'b0;
    w_kill = 1'b0;
    case (in_alu_ctrl)
      OP_ADD: begin
        w_res[WIDTH-1:0] = w_sum;
        w_ov = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
      end
      OP_SUB: begin
        w_res[WIDTH-1:0] = w_diff;
        w_ov = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
      end
      OP_AND: w_res[WIDTH-1:0] = w_a & w_b;
      OP_OR:  w_res[WIDTH-1:0] = w_a | w_b;
      OP_SLL: w_res[WIDTH-1:0] = w_a << w_b[SW-1:0];
      OP_SRL: w_res[WIDTH-1:0] = w_a >> w_b[SW-1:0];
      OP_ROL: w_res[WIDTH-1:0] = w_rol[2*WIDTH-1:WIDTH];
      OP_MUL, OP_DIV: begin
`ifdef STAGE_TWO_MULDIV_EN
        // A zero divisor is answered here in one cycle; it never starts the iterative unit.
        w_div0 = (in_alu_ctrl == OP_DIV) && (w_b == '0);
`else
        w_ill  = 1'b1;
        w_kill = 1'b1;
`endif
      end
      default: begin
        w_ill  = 1'b1;
        w_kill = 1'b1;
      end
    endcase
  end

`ifdef STAGE_TWO_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  state_e           r_state, w_state_nx;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
  logic             r_is_div, r_neg_a, r_neg_b;
  logic [1:0]       r_s_memc;
  logic             r_s_reg_wr, r_s_R0_en;
  logic [WIDTH-1:0] r_s_instr, r_s_R1;

  logic w_mc_op;
  assign w_mc_op = (in_alu_ctrl == OP_MUL) || ((in_alu_ctrl == OP_DIV) && (w_b != '0));

  assign busy = rst_n && (((r_state == S_IDLE) && w_mc_op) || (r_state == S_RUN));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_mc_op) w_state_nx = S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Both algorithms work on magnitudes; {r_hi, r_lo} is the product or {remainder, quotient}.
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  assign w_mag_a = w_a[MSB] ? -w_a : w_a;
  assign w_mag_b = w_b[MSB] ? -w_b : w_b;

  logic [WIDTH:0] w_mul_sum, w_rem_sh, w_trial;
  assign w_mul_sum = {1'b0, r_hi} + {1'b0, {WIDTH{r_lo[0]}} & r_opnd};
  assign w_rem_sh  = {r_hi, r_lo[MSB]};
  assign w_trial   = w_rem_sh - {1'b0, r_opnd};

  // NOTE: sequential state is written with non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_s_memc   <= '0;
      r_s_reg_wr <= 1'b0;
      r_s_R0_en  <= 1'b0;
      r_s_instr  <= '0;
      r_s_R1     <= '0;
    end else if (!halt_sys) begin
      r_state <= w_state_nx;
      case (r_state)
        S_IDLE: if (w_mc_op) begin
          r_is_div   <= (in_alu_ctrl == OP_DIV);
          r_neg_a    <= w_a[MSB];
          r_neg_b    <= w_b[MSB];
          r_hi       <= '0;
          r_lo       <= (in_alu_ctrl == OP_DIV) ? w_mag_a : w_mag_b;
          r_opnd     <= (in_alu_ctrl == OP_DIV) ? w_mag_b : w_mag_a;
          r_cnt      <= '0;
          r_s_memc   <= in_memc;
          r_s_reg_wr <= in_reg_wr;
          r_s_R0_en  <= in_R0_en;
          r_s_instr  <= in_instr;
          r_s_R1     <= w_r1;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            if (!w_trial[WIDTH]) begin
              r_hi <= w_trial[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_hi <= w_rem_sh[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Sign correction happens once, on the DONE cycle.
  logic               w_neg;
  logic [2*WIDTH-1:0] w_mag_prod, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH:0]     w_prod_top;
  logic               w_prod_ov, w_div_ov;
  assign w_neg      = r_neg_a ^ r_neg_b;
  assign w_mag_prod = {r_hi, r_lo};
  assign w_prod     = w_neg ? -w_mag_prod : w_mag_prod;
  assign w_quo      = w_neg ? -r_lo : r_lo;
  assign w_rem      = r_neg_a ? -r_hi : r_hi;
  assign w_prod_top = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_prod_ov  = !((&w_prod_top) || !(|w_prod_top));
  assign w_div_ov   = !w_neg && r_lo[MSB];
`else
  assign busy = 1'b0;
`endif

  logic [2*WIDTH-1:0] w_nx_alu;
  logic [1:0]         w_nx_memc;
  logic               w_nx_reg_wr, w_nx_R0_en, w_nx_ov, w_nx_div0, w_nx_ill;
  logic [WIDTH-1:0]   w_nx_instr, w_nx_R1;

  always_comb begin
    w_nx_alu    = w_res;
    w_nx_ov     = w_ov;
    w_nx_div0   = w_div0;
    w_nx_ill    = w_ill;
    w_nx_memc   = w_kill ? 2'b00 : in_memc;
    w_nx_reg_wr = in_reg_wr & ~w_kill;
    w_nx_R0_en  = in_R0_en & ~w_kill;
    w_nx_instr  = in_instr;
    w_nx_R1     = w_r1;
`ifdef STAGE_TWO_MULDIV_EN
    if (r_state == S_DONE) begin
      w_nx_alu    = r_is_div ? {w_rem, w_quo} : w_prod;
      w_nx_ov     = r_is_div ? w_div_ov : w_prod_ov;
      w_nx_div0   = 1'b0;
      w_nx_ill    = 1'b0;
      w_nx_memc   = r_s_memc;
      w_nx_reg_wr = r_s_reg_wr;
      w_nx_R0_en  = r_s_R0_en;
      w_nx_instr  = r_s_instr;
      w_nx_R1     = r_s_R1;
    end else if (busy) begin
      w_nx_alu    = '0;
      w_nx_ov     = 1'b0;
      w_nx_div0   = 1'b0;
      w_nx_ill    = 1'b0;
      w_nx_memc   = 2'b00;
      w_nx_reg_wr = 1'b0;
      w_nx_R0_en  = 1'b0;
      w_nx_instr  = '0;
      w_nx_R1     = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_alu     <= '0;
      out_memc    <= '0;
      out_reg_wr  <= 1'b0;
      out_R0_en   <= 1'b0;
      out_instr   <= '0;
      out_R1_data <= '0;
      overflow    <= 1'b0;
      div0        <= 1'b0;
      illegal     <= 1'b0;
    end else if (!halt_sys) begin
      out_alu     <= w_nx_alu;
      out_memc    <= w_nx_memc;
      out_reg_wr  <= w_nx_reg_wr;
      out_R0_en   <= w_nx_R0_en;
      out_instr   <= w_nx_instr;
      out_R1_data <= w_nx_R1;
      overflow    <= w_nx_ov;
      div0        <= w_nx_div0;
      illegal     <= w_nx_ill;
    end
  end

endmodule

// File: tb/tb_stage_two.sv
// Self-checking bench for stage_two: vector table, directed multi-cycle sequences and random ops
// against an arithmetic reference model. Expectations follow STAGE_TWO_MULDIV_EN when defined.
module tb_stage_two;
  localparam int W = 16;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                         SLL = 4'd4, SRL = 4'd5, ROL = 4'd6, MUL = 4'd7, DIV = 4'd8;

`ifdef STAGE_TWO_MULDIV_EN
  localparam int          EXP_STALL = 17;
  localparam logic [31:0] EXP_MUL   = 32'h0001_0000;
  localparam logic [31:0] EXP_DIV1  = 32'h0001_FFFD;
  localparam logic [31:0] EXP_DIV2  = 32'h0000_8000;
  localparam logic [31:0] EXP_HAZ   = 32'h0000_000C;
  localparam logic        EXP_OV    = 1'b1;
  localparam logic        EXP_D0    = 1'b1;
`else
  localparam int          EXP_STALL = 0;
  localparam logic [31:0] EXP_MUL   = 32'h0;
  localparam logic [31:0] EXP_DIV1  = 32'h0;
  localparam logic [31:0] EXP_DIV2  = 32'h0;
  localparam logic [31:0] EXP_HAZ   = 32'h0;
  localparam logic        EXP_OV    = 1'b0;
  localparam logic        EXP_D0    = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, halt_sys;
  logic [1:0]  in_memc;
  logic        in_reg_wr, in_R0_en, in_haz1, in_haz2, in_haz8;
  logic [31:0] in_alu, s3_data;
  logic [3:0]  in_alu_ctrl;
  logic [15:0] in_instr, in_R1_data;
  logic        busy, out_reg_wr, out_R0_en, overflow, div0, illegal;
  logic [31:0] out_alu;
  logic [1:0]  out_memc;
  logic [15:0] out_instr, out_R1_data;

  always #5 clk = ~clk;

  stage_two #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .halt_sys(halt_sys),
    .in_memc(in_memc), .in_reg_wr(in_reg_wr), .in_R0_en(in_R0_en),
    .in_alu(in_alu), .in_alu_ctrl(in_alu_ctrl),
    .in_haz1(in_haz1), .in_haz2(in_haz2), .in_haz8(in_haz8),
    .in_instr(in_instr), .in_R1_data(in_R1_data), .s3_data(s3_data),
    .busy(busy), .out_alu(out_alu), .out_memc(out_memc),
    .out_reg_wr(out_reg_wr), .out_R0_en(out_R0_en), .out_instr(out_instr),
    .out_R1_data(out_R1_data), .overflow(overflow), .div0(div0), .illegal(illegal)
  );

  int n_vec = 0;
  int n_err = 0;
  int last_stall;
  logic [31:0] last_exp_alu;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain signed integer arithmetic on the forwarded operands.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [31:0] alu, output logic ov, output logic d0,
                                output logic ill, output logic bub, output int stall);
    int sa, sb, r, q, rm, sh;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    alu = '0; ov = 1'b0; d0 = 1'b0; ill = 1'b0; bub = 1'b0; stall = 0;
    case (op)
      ADD: begin r = sa + sb; alu = {16'h0, r[15:0]}; ov = (r > 32767) || (r < -32768); end
      SUB: begin r = sa - sb; alu = {16'h0, r[15:0]}; ov = (r > 32767) || (r < -32768); end
      AND_: alu = {16'h0, a & b};
      OR_:  alu = {16'h0, a | b};
      SLL: begin r = int'(a) << sh; alu = {16'h0, r[15:0]}; end
      SRL: begin r = int'(a) >> sh; alu = {16'h0, r[15:0]}; end
      ROL: begin r = (int'(a) << sh) | (int'(a) >> (16 - sh)); alu = {16'h0, r[15:0]}; end
`ifdef STAGE_TWO_MULDIV_EN
      MUL: begin r = sa * sb; alu = r; ov = (r > 32767) || (r < -32768); stall = 17; end
      DIV: begin
        if (sb == 0) d0 = 1'b1;
        else begin
          q = sa / sb; rm = sa % sb;
          alu = {rm[15:0], q[15:0]}; ov = q > 32767; stall = 17;
        end
      end
`else
      MUL, DIV: begin ill = 1'b1; bub = 1'b1; end
`endif
      default: begin ill = 1'b1; bub = 1'b1; end
    endcase
  endfunction

  // Presents one op, waits (bounded) while busy checking bubbles, then checks the result.
  task automatic exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic h1, input logic h2, input logic h8,
                      input logic [31:0] s3, input logic [31:0] s3_late, input string tag);
    logic [15:0] fa, fb, fr1, instr, r1;
    logic [31:0] e_alu;
    logic e_ov, e_d0, e_ill, e_bub;
    logic [1:0] memc;
    int e_stall, stall;
    instr = 16'($urandom) | 16'h1;
    r1    = 16'($urandom);
    memc  = 2'($urandom_range(1, 3));
    fa  = h1 ? s3[15:0] : a;
    fb  = h2 ? s3[15:0] : b;
    fr1 = h8 ? s3[15:0] : r1;
    model(op, fa, fb, e_alu, e_ov, e_d0, e_ill, e_bub, e_stall);
    in_alu_ctrl = op; in_alu = {a, b};
    in_haz1 = h1; in_haz2 = h2; in_haz8 = h8; s3_data = s3;
    in_instr = instr; in_R1_data = r1; in_memc = memc; in_reg_wr = 1'b1; in_R0_en = 1'b1;
    #1;
    check({tag, " busy@E0"}, 32'(busy), 32'(e_stall > 0));
    stall = 0;
    while (busy && stall < 40) begin
      @(posedge clk); #1;
      stall++;
      if (stall == 1) s3_data = s3_late;
      check({tag, " bubble"}, {out_reg_wr, out_R0_en, out_memc, overflow, div0, illegal, out_instr}, 32'h0);
    end
    check({tag, " stall cycles"}, 32'(stall), 32'(e_stall));
    @(posedge clk); #1;
    check({tag, " alu"}, out_alu, e_alu);
    check({tag, " flags ov/div0/ill"}, {overflow, div0, illegal}, {e_ov, e_d0, e_ill});
    if (!e_d0) begin
      check({tag, " ctrl pass"}, {out_memc, out_reg_wr, out_R0_en}, e_bub ? 4'b0 : {memc, 2'b11});
      check({tag, " instr/R1"}, {out_instr, out_R1_data}, {instr, fr1});
    end
    last_stall   = stall;
    last_exp_alu = e_alu;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        h1, h2;
    logic [31:0] s3;
    logic [31:0] exp_alu;
    logic        exp_ov;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{ADD,  16'h7FFF, 16'h0001, 0, 0, 32'h0,         32'h0000_8000, 1'b1};
    tbl[1]  = '{ADD,  16'h1234, 16'h1111, 0, 0, 32'h0,         32'h0000_2345, 1'b0};
    tbl[2]  = '{SUB,  16'h8000, 16'h0001, 0, 0, 32'h0,         32'h0000_7FFF, 1'b1};
    tbl[3]  = '{SUB,  16'h0005, 16'h0007, 0, 0, 32'h0,         32'h0000_FFFE, 1'b0};
    tbl[4]  = '{AND_, 16'hF0F0, 16'h3C3C, 0, 0, 32'h0,         32'h0000_3030, 1'b0};
    tbl[5]  = '{OR_,  16'hF0F0, 16'h0F01, 0, 0, 32'h0,         32'h0000_FFF1, 1'b0};
    tbl[6]  = '{SLL,  16'h0001, 16'h0013, 0, 0, 32'h0,         32'h0000_0008, 1'b0};
    tbl[7]  = '{SRL,  16'h8000, 16'h000F, 0, 0, 32'h0,         32'h0000_0001, 1'b0};
    tbl[8]  = '{ROL,  16'h8001, 16'h0001, 0, 0, 32'h0,         32'h0000_0003, 1'b0};
    tbl[9]  = '{ROL,  16'h1234, 16'h0000, 0, 0, 32'h0,         32'h0000_1234, 1'b0};
    tbl[10] = '{ADD,  16'hAAAA, 16'h0001, 1, 0, 32'h0005_0010, 32'h0000_0011, 1'b0};
    tbl[11] = '{SUB,  16'h000A, 16'hBBBB, 0, 1, 32'hFFFF_0003, 32'h0000_0007, 1'b0};

    rst_n = 1'b0; halt_sys = 1'b0;
    in_memc = '0; in_reg_wr = 0; in_R0_en = 0; in_haz1 = 0; in_haz2 = 0; in_haz8 = 0;
    in_alu = '0; in_alu_ctrl = ADD; in_instr = '0; in_R1_data = '0; s3_data = '0;
    #12;
    check("reset outputs", {out_alu[15:0] | out_alu[31:16], out_instr | out_R1_data},
          32'h0);
    check("reset ctrl/flags", {out_memc, out_reg_wr, out_R0_en, overflow, div0, illegal, busy}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].h1, tbl[i].h2, 1'b0, tbl[i].s3, tbl[i].s3, "table");
      check($sformatf("table[%0d] alu", i), out_alu, tbl[i].exp_alu);
      check($sformatf("table[%0d] overflow", i), 32'(overflow), 32'(tbl[i].exp_ov));
    end

    // Multi-cycle corner cases.
    exec(MUL, 16'h0100, 16'h0100, 0, 0, 0, 32'h0, 32'h0, "mul 256*256");
    check("mul 256*256 const", out_alu, EXP_MUL);
    check("mul 256*256 ov", 32'(overflow), 32'(EXP_OV));
    check("mul stall count", 32'(last_stall), 32'(EXP_STALL));
    exec(DIV, 16'h0007, 16'hFFFE, 0, 0, 0, 32'h0, 32'h0, "div 7/-2");
    check("div 7/-2 const", out_alu, EXP_DIV1);
    exec(DIV, 16'h8000, 16'hFFFF, 0, 0, 0, 32'h0, 32'h0, "div min/-1");
    check("div min/-1 const", out_alu, EXP_DIV2);
    check("div min/-1 ov", 32'(overflow), 32'(EXP_OV));
    exec(DIV, 16'h0005, 16'h0000, 0, 0, 1, 32'h0, 32'h0, "div by 0");
    check("div by 0 const", {out_alu, div0, last_stall[0]}, {32'h0, EXP_D0, 1'b0});
    exec(MUL, 16'h7777, 16'h0004, 1, 0, 1, 32'h0000_0003, 32'h0000_0009, "mul fwd snapshot");
    check("mul fwd snapshot const", out_alu, EXP_HAZ);
    exec(MUL, 16'hFFFF, 16'h8000, 0, 0, 0, 32'h0, 32'h0, "mul back-to-back 1");
    exec(MUL, 16'h8000, 16'h8000, 0, 0, 0, 32'h0, 32'h0, "mul back-to-back 2");

    // halt_sys freezes the output register.
    in_alu_ctrl = ADD; in_alu = {16'h0001, 16'h0002}; in_haz1 = 0; in_haz2 = 0;
    halt_sys = 1'b1;
    @(posedge clk); #1;
    check("halt holds alu", out_alu, last_exp_alu);
    halt_sys = 1'b0;
    @(posedge clk); #1;
    check("after halt alu", out_alu, 32'h0000_0003);

    // Reset in the middle of a DIV.
    in_alu_ctrl = DIV; in_alu = {16'd100, 16'd7}; in_reg_wr = 1; in_R0_en = 1; in_memc = 2'b11;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid-div reset busy", 32'(busy), 32'h0);
    check("mid-div reset outputs", {out_alu[15:0] | out_alu[31:16], out_instr | out_R1_data}, 32'h0);
    check("mid-div reset ctrl", {out_memc, out_reg_wr, out_R0_en, overflow, div0, illegal}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    exec(ADD, 16'h0001, 16'h0001, 0, 0, 0, 32'h0, 32'h0, "add after reset");
    check("add after reset const", out_alu, 32'h0000_0002);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [15:0] a, b;
      op = 4'($urandom_range(0, 8));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 16'h0;
      if ($urandom_range(0, 9) == 0) begin a = 16'h8000; b = 16'hFFFF; end
      exec(op, a, b, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), $urandom, $urandom, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
